// File: rtl/line_window_3x3_if.sv
// Pixel-in / window-out stream bundle for the 3x3 neighbourhood generator.
// The master drives pixels and accepts windows; the slave is the generator.
interface line_window_3x3_if #(
   parameter int DATA_W = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     in_pixel;
   logic                  out_valid;
   logic                  out_ready;
   logic [9*DATA_W-1:0]   out_win;
   logic                  out_sof;
   logic                  out_eol;
   logic                  out_eof;

   modport master (
      output in_valid, in_pixel, out_ready,
      input  in_ready, out_valid, out_win, out_sof, out_eol, out_eof
   );

   modport slave (
      input  in_valid, in_pixel, out_ready,
      output in_ready, out_valid, out_win, out_sof, out_eol, out_eof
   );
endinterface

// File: rtl/line_window_3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window,
// one registered window per interior pixel of a padded raster frame.
module line_window_3x3 #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 258,
   parameter int IMG_H  = 34,
   parameter int COL_W  = 9,
   parameter int ROW_W  = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   line_window_3x3_if.slave s,
   output logic            busy
);
   logic [COL_W-1:0]      col_r;
   logic [ROW_W-1:0]      row_r;
   logic [DATA_W-1:0]     lb0_r [IMG_W];
   logic [DATA_W-1:0]     lb1_r [IMG_W];
   logic [DATA_W-1:0]     win_r [9];
   logic [DATA_W-1:0]     win_nxt_s [9];
   logic [9*DATA_W-1:0]   win_pack_s;
   logic [9*DATA_W-1:0]   out_win_r;
   logic                  out_valid_r;
   logic                  sof_r;
   logic                  eol_r;
   logic                  eof_r;
   logic [DATA_W-1:0]     lb0_rd_s;
   logic [DATA_W-1:0]     lb1_rd_s;
   logic                  accept_s;
   logic                  emit_s;
   logic                  xfer_s;
   logic                  last_col_s;
   logic                  last_row_s;
   logic                  sof_s;

   assign s.in_ready  = !clear && (!out_valid_r || s.out_ready);
   assign accept_s    = s.in_valid && s.in_ready;
   assign xfer_s      = out_valid_r && s.out_ready;
   assign last_col_s  = (col_r == COL_W'(IMG_W - 1));
   assign last_row_s  = (row_r == ROW_W'(IMG_H - 1));
   assign emit_s      = accept_s && (row_r >= ROW_W'(2)) && (col_r >= COL_W'(2));
   assign sof_s       = (row_r == ROW_W'(2)) && (col_r == COL_W'(2));
   assign lb0_rd_s    = lb0_r[col_r];
   assign lb1_rd_s    = lb1_r[col_r];

   assign s.out_valid = out_valid_r;
   assign s.out_win   = out_win_r;
   assign s.out_sof   = sof_r;
   assign s.out_eol   = eol_r;
   assign s.out_eof   = eof_r;
   assign busy        = (row_r != ROW_W'(0)) || (col_r != COL_W'(0)) || out_valid_r;

   // Shift window left one column; new column is {top=lb1, mid=lb0, bottom=pixel}
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         win_nxt_s[r*3]     = win_r[r*3 + 1];
         win_nxt_s[r*3 + 1] = win_r[r*3 + 2];
         win_nxt_s[r*3 + 2] = win_r[r*3 + 2];
      end
      win_nxt_s[2] = lb1_rd_s;
      win_nxt_s[5] = lb0_rd_s;
      win_nxt_s[8] = s.in_pixel;
      win_pack_s   = '0;
      for (int k = 0; k < 9; k++) begin
         win_pack_s[k*DATA_W +: DATA_W] = win_nxt_s[k];
      end
   end

   // Line buffers: contents are don't-care after reset, so no reset branch
   always_ff @(posedge clk) begin
      if (accept_s) begin
         lb1_r[col_r] <= lb0_rd_s;
         lb0_r[col_r] <= s.in_pixel;
      end
   end

   // Raster position of the next pixel to be accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_r <= COL_W'(0);
         row_r <= ROW_W'(0);
      end else if (clear) begin
         col_r <= COL_W'(0);
         row_r <= ROW_W'(0);
      end else if (accept_s) begin
         if (last_col_s) begin
            col_r <= COL_W'(0);
            row_r <= last_row_s ? ROW_W'(0) : row_r + ROW_W'(1);
         end else begin
            col_r <= col_r + COL_W'(1);
         end
      end
   end

   // 3x3 window shift registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 9; k++) begin
            win_r[k] <= DATA_W'(0);
         end
      end else if (accept_s) begin
         win_r <= win_nxt_s;
      end
   end

   // Output window register; a new window may replace the one being transferred
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_win_r   <= '0;
         sof_r       <= 1'b0;
         eol_r       <= 1'b0;
         eof_r       <= 1'b0;
      end else if (clear) begin
         out_valid_r <= 1'b0;
         sof_r       <= 1'b0;
         eol_r       <= 1'b0;
         eof_r       <= 1'b0;
      end else if (emit_s) begin
         out_valid_r <= 1'b1;
         out_win_r   <= win_pack_s;
         sof_r       <= sof_s;
         eol_r       <= last_col_s;
         eof_r       <= last_col_s && last_row_s;
      end else if (xfer_s) begin
         out_valid_r <= 1'b0;
         sof_r       <= 1'b0;
         eol_r       <= 1'b0;
         eof_r       <= 1'b0;
      end
   end
endmodule

// File: tb/tb_line_window_3x3.sv
// Randomized bench for line_window_3x3: windows observed on the output are
// compared with windows cut directly out of stored reference frames.
module tb_line_window_3x3;
   localparam int W      = 258;
   localparam int H      = 34;
   localparam int NWIN   = (W - 2) * (H - 2);
   localparam int BUDGET = 40000;

   logic clk;
   logic rst_n;
   logic clear;
   logic busy;

   line_window_3x3_if #(.DATA_W(8)) bus ();

   line_window_3x3 #(
      .DATA_W(8), .IMG_W(W), .IMG_H(H), .COL_W(9), .ROW_W(6)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(clear),
      .s    (bus),
      .busy (busy)
   );

   logic [7:0]  mem [2][H][W];
   logic [74:0] exp_q [$];
   logic [74:0] obs_q [$];
   int          n_assert;
   int          n_fail;
   bit          stream_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // record every completed output transfer as {sof, eol, eof, window}
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready)
         obs_q.push_back({bus.out_sof, bus.out_eol, bus.out_eof, bus.out_win});
   end

   function automatic logic [74:0] cur_out();
      return {bus.out_sof, bus.out_eol, bus.out_eof, bus.out_win};
   endfunction

   task automatic gen_frame(input int slot, input bit rnd);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            mem[slot][r][c] = rnd ? 8'($urandom) : 8'((r * W + c) % 256);
   endtask

   // reference: every interior pixel yields the 3x3 block ending at it
   task automatic build_expected(input int slot);
      logic [71:0] w;
      for (int r = 2; r < H; r++)
         for (int c = 2; c < W; c++) begin
            for (int k = 0; k < 9; k++)
               w[k*8 +: 8] = mem[slot][r - 2 + k / 3][c - 2 + k % 3];
            exp_q.push_back({(r == 2 && c == 2), (c == W - 1), (r == H - 1 && c == W - 1), w});
         end
   endtask

   task automatic stream(input int slot0, input int nfr, input int vpct, input int rpct, input bit stall);
      int cyc;
      bit acc;
      bit drv_done;
      cyc = 0;
      drv_done = 1'b0;
      stream_done = 1'b0;
      fork
         begin
            for (int f = 0; f < nfr; f++)
               for (int r = 0; r < H; r++)
                  for (int c = 0; c < W; c++) begin
                     acc = 1'b0;
                     while (!acc && cyc < BUDGET) begin
                        @(posedge clk); #1;
                        bus.in_valid = ($urandom_range(99) < vpct);
                        bus.in_pixel = mem[slot0 + f][r][c];
                        @(negedge clk);
                        acc = bus.in_valid && bus.in_ready;
                        cyc++;
                     end
                  end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            drv_done = 1'b1;
         end
         begin
            int k;
            k = 0;
            while (!drv_done) begin
               @(posedge clk); #1;
               k++;
               if (stall) bus.out_ready = ((k % 97) >= 5);
               else       bus.out_ready = ($urandom_range(99) < rpct);
            end
            bus.out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      stream_done = 1'b1;
      if (cyc >= BUDGET) begin
         n_assert++; n_fail++;
         $display("FAIL stream_timeout: cycles=%0d limit=%0d", cyc, BUDGET);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0;
      bus.in_valid = 1'b0; bus.in_pixel = 8'h00; bus.out_ready = 1'b1;
      #12;
      n_assert++;
      if ({bus.out_valid, bus.out_sof, bus.out_eol, bus.out_eof, busy} !== 5'b0) begin
         n_fail++; $display("FAIL reset_state: got %b want 00000", {bus.out_valid, bus.out_sof, bus.out_eol, bus.out_eof, busy});
      end
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      n_assert++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      for (int n = 0; n < 800; n++) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b1;
         bus.in_pixel = mem[0][n / W][n % W];
      end
      @(negedge clk);
      n_assert++;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midstream_valid: got %b want 1", bus.out_valid); end
      #2; rst_n = 1'b0; #1;
      n_assert++;
      if ({bus.out_valid, bus.out_sof, bus.out_eol, bus.out_eof, busy} !== 5'b0) begin
         n_fail++; $display("FAIL async_reset: got %b want 00000", {bus.out_valid, bus.out_sof, bus.out_eol, bus.out_eof, busy});
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      n_assert++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
      obs_q = {};
   endtask

   task automatic test_latency();
      bit early;
      logic [71:0] w;
      early = 1'b0;
      bus.out_ready = 1'b1;
      for (int n = 0; n <= 2 * W + 2; n++) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b1;
         bus.in_pixel = mem[0][n / W][n % W];
         @(negedge clk);
         if (bus.out_valid !== 1'b0) early = 1'b1;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      n_assert++;
      if (early) begin n_fail++; $display("FAIL latency_early: window seen before pixel (2,2) got 1 want 0"); end
      w = 72'h06_05_04_04_03_02_02_01_00;
      n_assert++;
      if ({bus.out_valid, bus.out_sof, bus.out_win} !== {1'b1, 1'b1, w}) begin
         n_fail++; $display("FAIL latency_first_window: got %b %b %h want 1 1 %h", bus.out_valid, bus.out_sof, bus.out_win, w);
      end
      @(posedge clk); #1; clear = 1'b1;
      @(posedge clk); #1; clear = 1'b0;
      obs_q = {};
   endtask

   task automatic test_full_frame();
      int n_sof, n_eol, n_eof;
      exp_q = {}; build_expected(0);
      obs_q = {};
      stream(0, 1, 100, 100, 1'b0);
      n_assert++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_assert++;
         if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_win[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      n_sof = 0; n_eol = 0; n_eof = 0;
      foreach (obs_q[i]) begin
         n_sof += int'(obs_q[i][74]); n_eol += int'(obs_q[i][73]); n_eof += int'(obs_q[i][72]);
      end
      n_assert++;
      if ({n_sof, n_eol, n_eof} !== {32'd1, 32'd32, 32'd1}) begin
         n_fail++; $display("FAIL full_flags: got sof=%0d eol=%0d eof=%0d want 1 32 1", n_sof, n_eol, n_eof);
      end
      if (obs_q.size() > 0) begin
         n_assert++;
         if (obs_q[0][71:0] !== 72'h06_05_04_04_03_02_02_01_00) begin
            n_fail++; $display("FAIL full_first: got %h want 060504040302020100", obs_q[0][71:0]);
         end
         n_assert++;
         if ({obs_q[obs_q.size()-1][72], obs_q[obs_q.size()-1][71:64]} !== {1'b1, 8'h43}) begin
            n_fail++; $display("FAIL full_last: got eof=%b px=%h want 1 43", obs_q[obs_q.size()-1][72], obs_q[obs_q.size()-1][71:64]);
         end
      end
   endtask

   task automatic test_backpressure();
      int nheld;
      exp_q = {}; build_expected(0);
      obs_q = {};
      nheld = 0;
      fork
         stream(0, 1, 100, 100, 1'b1);
         begin
            logic [74:0] snap;
            bit held;
            held = 1'b0;
            snap = '0;
            while (!stream_done) begin
               @(negedge clk);
               if (held) begin
                  n_assert++; nheld++;
                  if (cur_out() !== snap) begin n_fail++; $display("FAIL bp_hold: got %h want %h", cur_out(), snap); end
               end
               held = bus.out_valid && !bus.out_ready;
               if (held) begin
                  n_assert++;
                  if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
               end
               snap = cur_out();
            end
         end
      join
      n_assert++;
      if (nheld < 100) begin n_fail++; $display("FAIL bp_stalls: got %0d held cycles want >=100", nheld); end
      n_assert++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_assert++;
         if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_win[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_random_gaps();
      exp_q = {}; build_expected(0);
      obs_q = {};
      stream(0, 1, 80, 70, 1'b0);
      n_assert++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_assert++;
         if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_win[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int sof2;
      gen_frame(1, 1'b1);
      exp_q = {}; build_expected(0); build_expected(1);
      obs_q = {};
      stream(0, 2, 100, 90, 1'b0);
      n_assert++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_assert++;
         if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_win[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      sof2 = -1;
      for (int i = 1; i < obs_q.size(); i++)
         if (obs_q[i][74] && sof2 < 0) sof2 = i;
      n_assert++;
      if (sof2 < 0 || (obs_q.size() - sof2) != NWIN) begin
         n_fail++; $display("FAIL b2b_frame2_windows: got sof2=%0d total=%0d want %0d windows", sof2, obs_q.size(), NWIN);
      end
   endtask

   task automatic test_clear();
      bus.out_ready = 1'b1;
      for (int n = 0; n < 10 * W + 5; n++) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b1;
         bus.in_pixel = mem[0][n / W][n % W];
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_pixel = 8'hEE;
      bus.out_ready = 1'b0; clear = 1'b1;
      @(negedge clk);
      n_assert++;
      if ({bus.in_ready, bus.out_valid} !== 2'b01) begin
         n_fail++; $display("FAIL clear_cycle: got in_ready=%b out_valid=%b want 0 1", bus.in_ready, bus.out_valid);
      end
      @(posedge clk); #1;
      clear = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      @(negedge clk);
      n_assert++;
      if ({bus.out_valid, bus.out_sof, bus.out_eol, bus.out_eof, busy} !== 5'b0) begin
         n_fail++; $display("FAIL clear_state: got %b want 00000", {bus.out_valid, bus.out_sof, bus.out_eol, bus.out_eof, busy});
      end
      exp_q = {}; build_expected(0);
      obs_q = {};
      stream(0, 1, 100, 100, 1'b0);
      n_assert++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL clear_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_assert++;
         if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL clear_win[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail = 0;
      stream_done = 1'b0;
      gen_frame(0, 1'b0);
      test_reset();
      test_latency();
      test_full_frame();
      test_backpressure();
      test_random_gaps();
      test_back_to_back();
      test_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
